// File: rtl/config_bank_pkg.sv
// Shared types and helpers for the configuration latch bank controller.
// Holds the FSM state encoding, the phase timer width and the row-address range check.
package config_bank_pkg;

   localparam int PHASE_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      SETUP,
      PULSE,
      HOLD
   } state_t;

   // Frames aimed past the last word line are rejected rather than aliased.
   function automatic logic row_legal(input logic [31:0] addr, input int unsigned num_wl);
      return addr < num_wl;
   endfunction

endpackage

// File: rtl/config_phase_timer.sv
// Loadable down-counter that times each controller phase.
// It stops at zero, and last stays high until the next load.
module config_phase_timer
   import config_bank_pkg::*;
(
   input  logic               prog_clk,
   input  logic               reset,
   input  logic               load,
   input  logic [PHASE_W-1:0] load_val,
   output logic               last
);

   logic [PHASE_W-1:0] count;

   always_ff @(posedge prog_clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - PHASE_W'(1);
   end

   assign last = (count == '0);

endmodule

// File: rtl/config_latch_bank_ctrl.sv
// Word-line / bit-line sequencer for a NUM_WL x NUM_BL configuration latch bank.
// Each accepted frame runs SETUP -> PULSE -> HOLD. A clear request drives the bank-wide reset.
module config_latch_bank_ctrl
   import config_bank_pkg::*;
#(
   parameter int NUM_WL    = 8,
   parameter int NUM_BL    = 8,
   parameter int ADDR_W    = $clog2(NUM_WL),
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1,
   parameter int CLR_CYC   = 4
)(
   input  logic              prog_clk,
   input  logic              reset,
   input  logic              clr_req,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [NUM_BL-1:0] in_data,
   output logic [NUM_WL-1:0] wl,
   output logic [NUM_BL-1:0] bl,
   output logic              cfg_reset,
   output logic              busy,
   output logic              addr_err,
   output logic [ADDR_W:0]   frame_cnt
);

   localparam logic [PHASE_W-1:0] CLR_LD   = PHASE_W'(CLR_CYC - 1);
   localparam logic [PHASE_W-1:0] SETUP_LD = PHASE_W'(SETUP_CYC - 1);
   localparam logic [PHASE_W-1:0] PULSE_LD = PHASE_W'(PULSE_CYC - 1);
   localparam logic [PHASE_W-1:0] HOLD_LD  = PHASE_W'((HOLD_CYC == 0) ? 0 : HOLD_CYC - 1);
   localparam logic [ADDR_W:0]    CNT_MAX  = '1;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   row;
   logic                legal, accept, err_set, cnt_inc, clr_done;
   logic                load, last;
   logic [PHASE_W-1:0]  load_val;
   logic [NUM_WL-1:0]   wl_nxt;

   assign legal    = row_legal(32'(in_addr), NUM_WL);
   assign in_ready = (state == IDLE) && !clr_req;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      err_set   = 1'b0;
      cnt_inc   = 1'b0;
      clr_done  = 1'b0;
      case (state)
         IDLE: begin
            if (clr_req)
               state_nxt = CLEAR;
            else if (in_valid) begin
               if (legal) begin
                  accept    = 1'b1;
                  state_nxt = SETUP;
               end else
                  err_set = 1'b1;
            end
         end
         CLEAR: if (last) begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         SETUP: if (last) state_nxt = PULSE;
         PULSE: if (last) begin
            cnt_inc   = 1'b1;
            state_nxt = (HOLD_CYC == 0) ? IDLE : HOLD;
         end
         HOLD:  if (last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Every state change reloads the timer with the length of the state being entered.
   always_comb begin
      load     = (state_nxt != state);
      load_val = '0;
      case (state_nxt)
         CLEAR:   load_val = CLR_LD;
         SETUP:   load_val = SETUP_LD;
         PULSE:   load_val = PULSE_LD;
         HOLD:    load_val = HOLD_LD;
         default: load_val = '0;
      endcase
   end

   config_phase_timer u_timer (
      .prog_clk (prog_clk),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .last     (last)
   );

   // wl is decoded from the next state so that it is high during exactly the PULSE cycles.
   for (genvar i = 0; i < NUM_WL; i++) begin : g_wl
      assign wl_nxt[i] = (state_nxt == PULSE) && (row == ADDR_W'(i));
   end

   always_ff @(posedge prog_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         row       <= '0;
         wl        <= '0;
         bl        <= '0;
         cfg_reset <= 1'b0;
         addr_err  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         wl        <= wl_nxt;
         cfg_reset <= (state_nxt == CLEAR);
         if (accept) begin
            row <= in_addr;
            bl  <= in_data;
         end
         if (err_set)
            addr_err <= 1'b1;
         else if (clr_done)
            addr_err <= 1'b0;
         if (clr_done)
            frame_cnt <= '0;
         else if (cnt_inc && frame_cnt != CNT_MAX)
            frame_cnt <= frame_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_config_latch_bank_ctrl.sv
// Bench for config_latch_bank_ctrl: a default build (a) and a NUM_WL=6, 3/1/0 timing build (b)
// share stimulus. A timeline model predicts every output each cycle, and literal checks pin key points.
module tb_config_latch_bank_ctrl;

   logic       clk = 1'b0, rst = 1'b1;
   logic       clr_req = 1'b0, in_valid = 1'b0;
   logic [2:0] in_addr = '0;
   logic [7:0] in_data = '0;

   logic       rdy_a, cfg_a, busy_a, err_a;
   logic [7:0] wl_a, bl_a;
   logic [3:0] cnt_a;
   logic       rdy_b, cfg_b, busy_b, err_b;
   logic [5:0] wl_b;
   logic [7:0] bl_b;
   logic [3:0] cnt_b;

   int     n_cmp = 0, n_bad = 0;
   longint tick = 0;

   always #5 clk = ~clk;
   always @(posedge clk) tick <= tick + 1;

   config_latch_bank_ctrl #(.NUM_WL(8)) u_a (
      .prog_clk(clk), .reset(rst), .clr_req(clr_req), .in_valid(in_valid), .in_ready(rdy_a),
      .in_addr(in_addr), .in_data(in_data), .wl(wl_a), .bl(bl_a), .cfg_reset(cfg_a),
      .busy(busy_a), .addr_err(err_a), .frame_cnt(cnt_a));

   config_latch_bank_ctrl #(.NUM_WL(6), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(0)) u_b (
      .prog_clk(clk), .reset(rst), .clr_req(clr_req), .in_valid(in_valid), .in_ready(rdy_b),
      .in_addr(in_addr), .in_data(in_data), .wl(wl_b), .bl(bl_b), .cfg_reset(cfg_b),
      .busy(busy_b), .addr_err(err_b), .frame_cnt(cnt_b));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each handshake or clear schedules the cycle windows in which each output must show it.
   int S[2] = '{1, 3};
   int P[2] = '{2, 1};
   int H[2] = '{1, 0};
   int NW[2] = '{8, 6};
   localparam int CLR = 4, CMAX = 15;

   longint     cyc;
   longint     rdy_at[2], wl_from[2], wl_to[2], clr_from[2], clr_to[2], inc_at[2], zero_at[2];
   int         row[2], cnt[2];
   bit         err[2];
   logic [7:0] blm[2];

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         rdy_at[i] = cyc;  wl_from[i] = 1; wl_to[i] = 0; clr_from[i] = 1; clr_to[i] = 0;
         inc_at[i] = -1;   zero_at[i] = -1; row[i] = 0; cnt[i] = 0; err[i] = 0; blm[i] = '0;
      end
   endtask

   initial begin
      longint k;
      cyc = 0;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else begin
            k = cyc;
            for (int i = 0; i < 2; i++) begin
               if (k >= rdy_at[i]) begin
                  if (clr_req) begin
                     clr_from[i] = k + 1; clr_to[i] = k + CLR;
                     rdy_at[i] = k + CLR + 1; zero_at[i] = k + CLR + 1;
                  end else if (in_valid) begin
                     if (int'(in_addr) < NW[i]) begin
                        blm[i] = in_data; row[i] = int'(in_addr);
                        wl_from[i] = k + S[i] + 1; wl_to[i] = k + S[i] + P[i];
                        inc_at[i] = k + S[i] + P[i] + 1;
                        rdy_at[i] = k + S[i] + P[i] + H[i] + 1;
                     end else err[i] = 1'b1;
                  end
               end
               if (k + 1 == inc_at[i] && cnt[i] < CMAX) cnt[i]++;
               if (k + 1 == zero_at[i]) begin cnt[i] = 0; err[i] = 1'b0; end
            end
            cyc = k + 1;
         end
      end
   end

   task automatic cmp(input int i, input logic [7:0] wl, input logic [7:0] bl, input logic cfg,
                      input logic bsy, input logic rdy, input logic er, input logic [3:0] cn);
      longint     c;
      logic [7:0] wle;
      c = cyc;
      wle = (c >= wl_from[i] && c <= wl_to[i]) ? 8'(1 << row[i]) : 8'h00;
      chk($sformatf("m%0d wl c%0d", i, c), 64'(wl), 64'(wle));
      chk($sformatf("m%0d bl c%0d", i, c), 64'(bl), 64'(blm[i]));
      chk($sformatf("m%0d cfg_reset c%0d", i, c), 64'(cfg), 64'(c >= clr_from[i] && c <= clr_to[i]));
      chk($sformatf("m%0d busy c%0d", i, c), 64'(bsy), 64'(c < rdy_at[i]));
      chk($sformatf("m%0d in_ready c%0d", i, c), 64'(rdy), 64'(!(c < rdy_at[i]) && !clr_req));
      chk($sformatf("m%0d addr_err c%0d", i, c), 64'(er), 64'(err[i]));
      chk($sformatf("m%0d frame_cnt c%0d", i, c), 64'(cn), 64'(cnt[i]));
   endtask

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         cmp(0, wl_a, bl_a, cfg_a, busy_a, rdy_a, err_a, cnt_a);
         cmp(1, {2'b00, wl_b}, bl_b, cfg_b, busy_b, rdy_b, err_b, cnt_b);
      end
   end

   task automatic wait_rdy();
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (rdy_a === 1'b1) begin #1; return; end
      end
      chk("ready timeout", 64'd0, 64'd1);
      #1;
   endtask

   // Leaves in_valid high; returns 1ns into the first cycle after the handshake edge.
   task automatic send(input logic [2:0] a, input logic [7:0] d, output longint hs);
      @(posedge clk); #1;
      in_addr = a; in_data = d; in_valid = 1'b1;
      wait_rdy();
      @(posedge clk); #1;
      hs = tick;
   endtask

   initial begin
      longint hs, hs_prev;
      int     n;
      repeat (3) @(negedge clk);
      chk("reset wl", 64'(wl_a), 64'd0);
      chk("reset bl", 64'(bl_a), 64'd0);
      chk("reset cfg_reset", 64'(cfg_a), 64'd0);
      chk("reset busy", 64'(busy_a), 64'd0);
      chk("reset frame_cnt", 64'(cnt_a), 64'd0);
      chk("reset addr_err", 64'(err_a), 64'd0);
      chk("reset in_ready", 64'(rdy_a), 64'd1);
      @(posedge clk); #1 rst = 1'b0;

      // single frame: row 3, data A5
      send(3'd3, 8'hA5, hs);
      in_valid = 1'b0;
      @(negedge clk); chk("t1 bl c1", 64'(bl_a), 64'hA5); chk("t1 wl c1", 64'(wl_a), 64'h00);
      @(negedge clk); chk("t1 wl c2", 64'(wl_a), 64'h08);
      @(negedge clk); chk("t1 wl c3", 64'(wl_a), 64'h08); chk("t1 b wl c3", 64'(wl_b), 64'h00);
      @(negedge clk); chk("t1 wl c4", 64'(wl_a), 64'h00); chk("t1 cnt c4", 64'(cnt_a), 64'd1);
      chk("t1 b wl c4", 64'(wl_b), 64'h08);
      @(negedge clk); chk("t1 ready c5", 64'(rdy_a), 64'd1); chk("t1 b ready c5", 64'(rdy_b), 64'd1);

      // eight back-to-back frames; rows 6 and 7 are illegal for build b
      hs_prev = 0;
      for (int a = 0; a < 8; a++) begin
         send(3'(a), 8'(a * 17 + 1), hs);
         if (a > 0) chk($sformatf("burst interval %0d", a), 64'(hs - hs_prev), 64'd5);
         hs_prev = hs;
      end
      in_valid = 1'b0;
      wait_rdy();
      chk("burst cnt a", 64'(cnt_a), 64'd9);
      chk("burst cnt b", 64'(cnt_b), 64'd7);
      chk("burst err a", 64'(err_a), 64'd0);
      chk("burst err b", 64'(err_b), 64'd1);

      // clear with a frame pending
      @(posedge clk); #1;
      clr_req = 1'b1; in_valid = 1'b1; in_addr = 3'd2; in_data = 8'h3C;
      @(negedge clk); chk("clr ready a", 64'(rdy_a), 64'd0); chk("clr ready b", 64'(rdy_b), 64'd0);
      @(posedge clk); #1 clr_req = 1'b0;
      n = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (cfg_a) n++;
         if (k <= 4) chk($sformatf("clr wl c%0d", k), 64'(wl_a), 64'd0);
      end
      chk("clr pulse width", 64'(n), 64'd4);
      chk("clr cnt a", 64'(cnt_a), 64'd0);
      chk("clr err b", 64'(err_b), 64'd0);
      chk("clr post ready", 64'(rdy_a), 64'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk); chk("clr frame bl", 64'(bl_a), 64'h3C); chk("clr frame busy", 64'(busy_a), 64'd1);
      #1;
      wait_rdy();

      // reset during the second PULSE cycle of a row-5 frame, starting from frame_cnt 0
      @(posedge clk); #1 clr_req = 1'b1;
      @(posedge clk); #1 clr_req = 1'b0;
      wait_rdy();
      send(3'd5, 8'h5A, hs);
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst pulse wl", 64'(wl_a), 64'h20);
      #2 rst = 1'b1;
      #1;
      chk("rst async wl", 64'(wl_a), 64'd0);
      chk("rst async busy", 64'(busy_a), 64'd0);
      chk("rst async cnt", 64'(cnt_a), 64'd0);
      chk("rst async bl", 64'(bl_a), 64'd0);
      chk("rst async ready", 64'(rdy_a), 64'd1);
      @(posedge clk); #1 rst = 1'b0;

      send(3'd1, 8'hC3, hs);
      in_valid = 1'b0;
      wait_rdy();
      chk("post rst cnt", 64'(cnt_a), 64'd1);
      chk("post rst bl", 64'(bl_a), 64'hC3);
      repeat (3) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
